// File: rtl/idct_block_scheduler_pkg.sv
// Shared types for the IDCT block scheduler: sequencer states, plane codes
// and the plane/row/col block coordinate.
package idct_block_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LI_FS,
    CT_LAUNCH,
    CT_WAIT,
    CS_LAUNCH,
    CS_WAIT,
    LO_WS,
    DONE
  } IDCT_SCHED_state_type;

  localparam logic [1:0] PLANE_Y = 2'd0;
  localparam logic [1:0] PLANE_U = 2'd1;
  localparam logic [1:0] PLANE_V = 2'd2;

  typedef struct packed {
    logic [1:0] plane;
    logic [4:0] row;
    logic [5:0] col;
  } block_coord_t;

endpackage

// File: rtl/idct_block_scheduler_if.sv
// Handshake bundle between the scheduler (master) and the top-level FSM plus
// the fetch, multiplier and write-back units (slave).
interface idct_block_scheduler_if;

  logic       start;
  logic       done;
  logic       FS_start;
  logic       FS_done;
  logic [1:0] FS_plane;
  logic [4:0] FS_block_row;
  logic [5:0] FS_block_col;
  logic       MM_start;
  logic       MM_done;
  logic       T_S;
  logic       WS_start;
  logic       WS_done;
  logic [1:0] WS_plane;
  logic [4:0] WS_block_row;
  logic [5:0] WS_block_col;

  modport master (
    input  start, FS_done, MM_done, WS_done,
    output done, FS_start, FS_plane, FS_block_row, FS_block_col,
           MM_start, T_S, WS_start, WS_plane, WS_block_row, WS_block_col
  );

  modport slave (
    output start, FS_done, MM_done, WS_done,
    input  done, FS_start, FS_plane, FS_block_row, FS_block_col,
           MM_start, T_S, WS_start, WS_plane, WS_block_row, WS_block_col
  );

endinterface

// File: rtl/idct_block_scheduler_block_coord_iter.sv
// Plane/row/col block iterator: Y plane row-major, then U, then V, with the
// UV planes using the narrower column count.
module block_coord_iter
  import idct_block_scheduler_pkg::*;
#(
  parameter int Y_COLS  = 40,
  parameter int UV_COLS = 20,
  parameter int ROWS    = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output block_coord_t o_coord
);

  block_coord_t r_coord;
  logic [5:0]   w_last_col;

  always_comb begin
    w_last_col = (r_coord.plane == PLANE_Y) ? 6'(Y_COLS - 1) : 6'(UV_COLS - 1);
  end

  // NOTE: every field update is non-blocking, so the wrap tests below all see
  // the coordinate as it stood before this edge.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_coord <= '0;
    end else if (i_inc) begin
      if (r_coord.col == w_last_col) begin
        r_coord.col <= '0;
        if (r_coord.row == 5'(ROWS - 1)) begin
          r_coord.row   <= '0;
          r_coord.plane <= r_coord.plane + 2'd1;
        end else begin
          r_coord.row <= r_coord.row + 5'd1;
        end
      end else begin
        r_coord.col <= r_coord.col + 6'd1;
      end
    end
  end

  assign o_coord = r_coord;

endmodule

// File: rtl/idct_block_scheduler.sv
// IDCT block sequencer: per block launches fetch, T multiply, S multiply and
// write-back, overlapping WS(n-1) with CT(n) and FS(n+1) with CS(n).
module idct_block_scheduler
  import idct_block_scheduler_pkg::*;
#(
  parameter int Y_COLS  = 40,
  parameter int UV_COLS = 20,
  parameter int ROWS    = 30
) (
  input logic                     CLOCK_50_I,
  input logic                     Resetn,
  idct_block_scheduler_if.master  bus
);

  localparam int         N_BLOCKS = ROWS * (Y_COLS + 2 * UV_COLS);
  localparam logic [11:0] LAST_BLK = 12'(N_BLOCKS - 1);

  IDCT_SCHED_state_type r_state;
  logic [11:0]  r_cur;
  logic         r_pend_fs, r_pend_mm, r_pend_ws;
  logic         r_fs_d1, r_fs_d2, r_mm_d1, r_mm_d2, r_ws_d1, r_ws_d2;
  logic         r_done, r_fs_start, r_mm_start, r_t_s, r_ws_start;
  block_coord_t r_fs_coord, r_ws_coord;
  block_coord_t w_fetch, w_write;
  logic         w_fs_cpl, w_mm_cpl, w_ws_cpl, w_joined, w_iter_clr;

  // A completion is a registered rising edge on a unit that has a launch pending.
  assign w_fs_cpl   = r_fs_d1 & ~r_fs_d2 & r_pend_fs;
  assign w_mm_cpl   = r_mm_d1 & ~r_mm_d2 & r_pend_mm;
  assign w_ws_cpl   = r_ws_d1 & ~r_ws_d2 & r_pend_ws;
  assign w_joined   = ~(r_pend_fs | r_pend_mm | r_pend_ws);
  assign w_iter_clr = (r_state == DONE);

  block_coord_iter #(.Y_COLS(Y_COLS), .UV_COLS(UV_COLS), .ROWS(ROWS)) u_fetch_iter (
    .clk(CLOCK_50_I), .rst(Resetn), .i_clr(w_iter_clr), .i_inc(w_fs_cpl), .o_coord(w_fetch)
  );

  block_coord_iter #(.Y_COLS(Y_COLS), .UV_COLS(UV_COLS), .ROWS(ROWS)) u_write_iter (
    .clk(CLOCK_50_I), .rst(Resetn), .i_clr(w_iter_clr), .i_inc(w_ws_cpl), .o_coord(w_write)
  );

  always_ff @(posedge CLOCK_50_I) begin
    if (Resetn) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_pend_fs  <= 1'b0;
      r_pend_mm  <= 1'b0;
      r_pend_ws  <= 1'b0;
      r_fs_d1    <= 1'b0;
      r_fs_d2    <= 1'b0;
      r_mm_d1    <= 1'b0;
      r_mm_d2    <= 1'b0;
      r_ws_d1    <= 1'b0;
      r_ws_d2    <= 1'b0;
      r_done     <= 1'b0;
      r_fs_start <= 1'b0;
      r_mm_start <= 1'b0;
      r_t_s      <= 1'b0;
      r_ws_start <= 1'b0;
      r_fs_coord <= '0;
      r_ws_coord <= '0;
    end else begin
      r_fs_d1    <= bus.FS_done;
      r_fs_d2    <= r_fs_d1;
      r_mm_d1    <= bus.MM_done;
      r_mm_d2    <= r_mm_d1;
      r_ws_d1    <= bus.WS_done;
      r_ws_d2    <= r_ws_d1;
      r_done     <= 1'b0;
      r_fs_start <= 1'b0;
      r_mm_start <= 1'b0;
      r_ws_start <= 1'b0;
      if (w_fs_cpl) r_pend_fs <= 1'b0;
      if (w_mm_cpl) r_pend_mm <= 1'b0;
      if (w_ws_cpl) r_pend_ws <= 1'b0;

      case (r_state)
        IDLE: if (bus.start) begin
          r_fs_start <= 1'b1;
          r_fs_coord <= w_fetch;
          r_pend_fs  <= 1'b1;
          r_state    <= LI_FS;
        end
        LI_FS: if (!r_pend_fs) r_state <= CT_LAUNCH;
        CT_LAUNCH: begin
          r_t_s      <= 1'b0;
          r_mm_start <= 1'b1;
          r_pend_mm  <= 1'b1;
          if (r_cur != '0) begin
            r_ws_start <= 1'b1;
            r_ws_coord <= w_write;
            r_pend_ws  <= 1'b1;
          end
          r_state <= CT_WAIT;
        end
        CT_WAIT: if (w_joined) r_state <= CS_LAUNCH;
        CS_LAUNCH: begin
          r_t_s      <= 1'b1;
          r_mm_start <= 1'b1;
          r_pend_mm  <= 1'b1;
          if (r_cur != LAST_BLK) begin
            r_fs_start <= 1'b1;
            r_fs_coord <= w_fetch;
            r_pend_fs  <= 1'b1;
          end
          r_state <= CS_WAIT;
        end
        CS_WAIT: if (w_joined) begin
          if (r_cur == LAST_BLK) begin
            r_ws_start <= 1'b1;
            r_ws_coord <= w_write;
            r_pend_ws  <= 1'b1;
            r_state    <= LO_WS;
          end else begin
            r_cur   <= r_cur + 12'd1;
            r_state <= CT_LAUNCH;
          end
        end
        LO_WS: if (!r_pend_ws) r_state <= DONE;
        DONE: begin
          r_done  <= 1'b1;
          r_cur   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.done         = r_done;
  assign bus.FS_start     = r_fs_start;
  assign bus.FS_plane     = r_fs_coord.plane;
  assign bus.FS_block_row = r_fs_coord.row;
  assign bus.FS_block_col = r_fs_coord.col;
  assign bus.MM_start     = r_mm_start;
  assign bus.T_S          = r_t_s;
  assign bus.WS_start     = r_ws_start;
  assign bus.WS_plane     = r_ws_coord.plane;
  assign bus.WS_block_row = r_ws_coord.row;
  assign bus.WS_block_col = r_ws_coord.col;

endmodule
